// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read,
// and buffers {instruction, pc} pairs in a small FIFO for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     req_pc_q;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic accept;
  logic push;
  logic pop;
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  assign imem_req_valid = !rst && (state_q == S_IDLE)
                        && (cnt_q < CW'(DEPTH))
                        && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;

  assign accept = imem_req_valid && imem_req_ready;
  assign push   = (state_q == S_WAIT) && imem_resp_valid
                && !redirect_valid;
  assign pop    = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (cnt_q != '0);
  assign inst_out   = data_q[rd_q];
  assign inst_pc    = pc_q[rd_q];

  // A response always frees the outstanding slot, even under redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_resp_valid)     state_q <= S_IDLE;
          else if (redirect_valid) state_q <= S_DROP;
        end
        S_DROP: if (imem_resp_valid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (redirect_valid)
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        fetch_pc_q <= fetch_pc_q + 32'd4;
      if (accept)
        req_pc_q <= fetch_pc_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (redirect_valid) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_resp_data;
      pc_q[wr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming fetch,
// hand sequences for backpressure, redirect, stall, wrap and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        req_ready;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        t_rv;
  logic [31:0] t_rd;
  logic        auto_m;
  int          lat;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic        req_valid, w_rv;
  logic [31:0] req_addr, w_addr;
  logic        inst_valid, w_iv;
  logic [31:0] inst_out, w_out;
  logic [31:0] inst_pc, w_pc;

  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  int n_chk;
  int n_fail;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u0 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready),
    .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_rv), .imem_req_ready(req_ready),
    .imem_req_addr(w_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .inst_valid(w_iv), .inst_ready(inst_ready),
    .inst_out(w_out), .inst_pc(w_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: answers each accepted request after lat cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_addr <= '0;
    end else if (m_pend) begin
      if (m_cnt == 1) m_pend <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end else if (auto_m && req_valid && req_ready) begin
      m_pend <= 1'b1;
      m_cnt  <= lat;
      m_addr <= req_addr;
    end
  end

  assign resp_valid = auto_m ? (m_pend && m_cnt == 1) : t_rv;
  assign resp_data  = auto_m ? (m_addr ^ 32'hA5A5_0000) : t_rd;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] epc;
    logic [31:0] eout;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_ready      = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    t_rv           = 1'b0;
    t_rd           = '0;
    auto_m         = 1'b0;
    lat            = 1;
    #1;
    chk1("rst_req_valid", req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_addr", req_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vt[0] = '{1'b1, 1'b0, 32'h0,         1'b1,
              1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'hA5A5_0000, 1'b1,
              1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0,         1'b1,
              1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000};
    vt[3] = '{1'b1, 1'b1, 32'hA5A5_0004, 1'b1,
              1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h0,         1'b1,
              1'b1, 32'h8, 1'b1, 32'h4, 32'hA5A5_0004};
    vt[5] = '{1'b1, 1'b1, 32'hA5A5_0008, 1'b1,
              1'b0, 32'hC, 1'b0, 32'h0, 32'h0};
    vt[6] = '{1'b0, 1'b0, 32'h0,         1'b1,
              1'b1, 32'hC, 1'b1, 32'h8, 32'hA5A5_0008};
    vt[7] = '{1'b0, 1'b0, 32'h0,         1'b1,
              1'b1, 32'hC, 1'b0, 32'h0, 32'h0};

    // Streaming with single-cycle memory
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_ready  = vt[i].rdy;
      t_rv       = vt[i].rv;
      t_rd       = vt[i].rd;
      inst_ready = vt[i].ir;
      #1;
      chk1($sformatf("t1_req_valid[%0d]", i), req_valid, vt[i].ev);
      chk($sformatf("t1_addr[%0d]", i), req_addr, vt[i].ea);
      chk1($sformatf("t1_inst_valid[%0d]", i), inst_valid, vt[i].eiv);
      if (vt[i].eiv) begin
        chk($sformatf("t1_pc[%0d]", i), inst_pc, vt[i].epc);
        chk($sformatf("t1_out[%0d]", i), inst_out, vt[i].eout);
      end
      cyc();
    end

    // Backpressure: FIFO fills, one pop releases the next request
    do_reset();
    auto_m = 1'b1; lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (8) cyc();
    #1;
    chk1("bp_full_req_valid", req_valid, 1'b0);
    chk1("bp_full_inst_valid", inst_valid, 1'b1);
    chk("bp_full_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    chk1("bp_resume_valid", req_valid, 1'b1);
    chk("bp_resume_addr", req_addr, 32'h10);
    chk("bp_resume_head", inst_pc, 32'h4);
    cyc();
    req_ready = 1'b0;
    cyc();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 0) chk1("bp_refull_req_valid", req_valid, 1'b0);
      chk($sformatf("bp_order_pc[%0d]", i), inst_pc, 32'(4 + 4 * i));
      chk($sformatf("bp_order_out[%0d]", i), inst_out,
          32'(4 + 4 * i) ^ 32'hA5A5_0000);
      cyc();
    end
    #1;
    chk1("bp_drained", inst_valid, 1'b0);

    // Redirect while a slow request is outstanding
    do_reset();
    auto_m = 1'b1; lat = 3; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (9) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk1("rw_redir_inst_valid", inst_valid, 1'b1);
    chk1("rw_redir_req_valid", req_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk1("rw_flushed", inst_valid, 1'b0);
    chk1("rw_drop_req_valid", req_valid, 1'b0);
    chk("rw_new_addr", req_addr, 32'h100);
    cyc();
    #1;
    chk1("rw_drop_resp_req_valid", req_valid, 1'b0);
    chk1("rw_drop_resp_inst_valid", inst_valid, 1'b0);
    cyc();
    #1;
    chk1("rw_refetch_valid", req_valid, 1'b1);
    chk("rw_refetch_addr", req_addr, 32'h100);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("rw_no_stale[%0d]", i), inst_valid, 1'b0);
      cyc();
    end
    #1;
    chk1("rw_new_inst_valid", inst_valid, 1'b1);
    chk("rw_new_pc", inst_pc, 32'h100);
    chk("rw_new_out", inst_out, 32'hA5A5_0100);

    // Redirect coinciding with a WAIT response and a pop
    do_reset();
    auto_m = 1'b1; lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rr_head_pc", inst_pc, 32'h0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    inst_ready     = 1'b1;
    #1;
    chk1("rr_resp_present", resp_valid, 1'b1);
    chk1("rr_req_valid", req_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk1("rr_flushed", inst_valid, 1'b0);
    chk1("rr_next_req_valid", req_valid, 1'b1);
    chk("rr_next_addr", req_addr, 32'h200);
    cyc();
    cyc();
    #1;
    chk1("rr_new_valid", inst_valid, 1'b1);
    chk("rr_new_pc", inst_pc, 32'h200);
    chk("rr_new_out", inst_out, 32'hA5A5_0200);

    // Memory not ready: request held, then redirect
    do_reset();
    auto_m = 1'b1; lat = 1; req_ready = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1($sformatf("st_req_valid[%0d]", i), req_valid, 1'b1);
      chk($sformatf("st_addr[%0d]", i), req_addr, 32'h0);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    chk1("st_redir_req_valid", req_valid, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk1("st_after_req_valid", req_valid, 1'b1);
    chk("st_after_addr", req_addr, 32'h40);

    // PC wrap and asynchronous reset mid-WAIT
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0;
    #1;
    chk1("wr_req_valid0", w_rv, 1'b1);
    chk("wr_addr0", w_addr, 32'hFFFF_FFF8);
    cyc();
    t_rv = 1'b1; t_rd = 32'h1111_0000;
    #1;
    chk("wr_addr1", w_addr, 32'hFFFF_FFFC);
    cyc();
    t_rv = 1'b0;
    #1;
    chk1("wr_req_valid2", w_rv, 1'b1);
    chk("wr_addr2", w_addr, 32'hFFFF_FFFC);
    chk1("wr_inst_valid2", w_iv, 1'b1);
    chk("wr_pc2", w_pc, 32'hFFFF_FFF8);
    chk("wr_out2", w_out, 32'h1111_0000);
    cyc();
    t_rv = 1'b1; t_rd = 32'h2222_0000;
    cyc();
    t_rv = 1'b0;
    #1;
    chk1("wr_req_valid4", w_rv, 1'b1);
    chk("wr_addr4", w_addr, 32'h0000_0000);
    cyc();
    #1;
    chk1("wr_wait_req_valid", w_rv, 1'b0);
    chk1("wr_pre_rst_inst_valid", w_iv, 1'b1);
    rst = 1'b1;
    #1;
    chk1("wr_async_req_valid", w_rv, 1'b0);
    chk1("wr_async_inst_valid", w_iv, 1'b0);
    chk("wr_async_addr", w_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_ready = 1'b0;
    t_rv      = 1'b1;
    t_rd      = 32'h3333_0000;
    #1;
    chk1("wr_post_req_valid", w_rv, 1'b1);
    chk("wr_post_addr", w_addr, 32'hFFFF_FFF8);
    chk1("wr_post_inst_valid", w_iv, 1'b0);
    cyc();
    t_rv = 1'b0;
    #1;
    chk1("wr_ignored_inst_valid", w_iv, 1'b0);
    chk1("wr_ignored_req_valid", w_rv, 1'b1);
    chk("wr_ignored_addr", w_addr, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
